// File: rtl/wb_write_sched_pkg.sv
// Package for the writeback write scheduler.
// Holds the FSM state encoding, default values for the scheduler
// parameters, the MDU queue entry layout and a small helper used to form
// even/odd register pair addresses.
package sparc_wb_pkg;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_FIFO_DEPTH   = 2;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    LOW_PEND = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } mdu_entry_t;

  // Builds a register address from a pair index and the odd/even select.
  function automatic logic [4:0] pairAddr(input logic [3:0] pairIdx, input logic odd);
    return {pairIdx, odd};
  endfunction

endpackage

// File: rtl/wb_write_sched_if.sv
// Bus bundle for the writeback write scheduler.
// Carries the writeback-stage request (pipe_*), the multi-cycle unit
// result handshake (mdu_*), the register-file write port (rf_*) and busy.
//   master : environment side (drives requests, observes port/status)
//   slave  : scheduler side (consumes requests, drives port/status)
interface wb_write_sched_if;

  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_data;
  logic        pipe_double;
  logic        pipe_stall;

  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        busy;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, pipe_double,
    output mdu_valid, mdu_rd, mdu_data,
    input  pipe_stall, mdu_ready,
    input  rf_we, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, pipe_double,
    input  mdu_valid, mdu_rd, mdu_data,
    output pipe_stall, mdu_ready,
    output rf_we, rf_waddr, rf_wdata, busy
  );

endinterface

// File: rtl/wb_write_sched_mdu_fifo.sv
// Small circular FIFO holding MDU results waiting for the write port.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   push_i      : write pushData_i (ignored when full)
//   pushData_i  : entry to enqueue
//   pop_i       : drop the head entry (ignored when empty)
//   head_o      : oldest entry, valid while !empty_o
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
module wb_mdu_fifo
  import sparc_wb_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  mdu_entry_t pushData_i,
  input  logic       pop_i,
  output mdu_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  mdu_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + 1'b1;
  endfunction

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign head_o  = mem_q[rdPtr_q];

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = nextPtr(wrPtr_q);
    if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
    // Push and pop together leave the occupancy unchanged.
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/wb_write_sched.sv
// Writeback write scheduler: arbitrates a single registered register-file
// write port between the writeback pipeline and queued MDU results.
// Doubleword pipe writes take two slots (high word to the even register,
// then low word to the odd register) and stall the pipe for the second.
// Queued MDU results that wait STARVE_LIMIT cycles force a grant.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : wb_write_sched_if slave modport (pipe_*, mdu_*, rf_*, busy)
module wb_write_sched
  import sparc_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  wb_write_sched_if.slave  bus
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

  wb_state_t        state_q, state_d;
  logic [3:0]       lowPair_q, lowPair_d;
  logic [31:0]      lowData_q, lowData_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             rfWe_q;
  logic [4:0]       rfWaddr_q;
  logic [31:0]      rfWdata_q;

  mdu_entry_t  pushEntry, headEntry;
  logic        fifoFull, fifoEmpty, mduPush, headPop;
  logic        forced, stall, grant;
  logic [4:0]  grantAddr;
  logic [31:0] grantData;

  // Ready comes from the registered occupancy only, so a pop in the same
  // cycle never opens the queue to a push while it is full.
  assign pushEntry = '{rd: bus.mdu_rd, data: bus.mdu_data};
  assign mduPush   = bus.mdu_valid && !fifoFull;

  wb_mdu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) uMduFifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (mduPush),
    .pushData_i (pushEntry),
    .pop_i      (headPop),
    .head_o     (headEntry),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  // A starved head takes the port away from the pipe, but never while the
  // second half of a doubleword is still owed.
  assign forced = (state_q == IDLE) && !fifoEmpty && (age_q == AGE_LIMIT);

  always_comb begin
    state_d   = state_q;
    lowPair_d = lowPair_q;
    lowData_d = lowData_q;
    grant     = 1'b0;
    grantAddr = '0;
    grantData = '0;
    headPop   = 1'b0;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        if (forced) begin
          stall     = 1'b1;
          grant     = 1'b1;
          grantAddr = headEntry.rd;
          grantData = headEntry.data;
          headPop   = 1'b1;
        end else if (bus.pipe_valid) begin
          grant = 1'b1;
          if (bus.pipe_double) begin
            grantAddr = pairAddr(bus.pipe_rd[4:1], 1'b0);
            grantData = bus.pipe_data[63:32];
            lowPair_d = bus.pipe_rd[4:1];
            lowData_d = bus.pipe_data[31:0];
            state_d   = LOW_PEND;
          end else begin
            grantAddr = bus.pipe_rd;
            grantData = bus.pipe_data[31:0];
          end
        end else if (!fifoEmpty) begin
          grant     = 1'b1;
          grantAddr = headEntry.rd;
          grantData = headEntry.data;
          headPop   = 1'b1;
        end
      end
      LOW_PEND: begin
        stall     = 1'b1;
        grant     = 1'b1;
        grantAddr = pairAddr(lowPair_q, 1'b1);
        grantData = lowData_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Age tracks how long the current head has waited; any pop hands the
  // count to a fresh head, so it restarts from zero.
  always_comb begin
    age_d = age_q;
    if (fifoEmpty || headPop) begin
      age_d = '0;
    end else if (age_q != AGE_LIMIT) begin
      age_d = age_q + 1'b1;
    end
  end

  // Writes to r0 still consume the slot; only the enable is suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lowPair_q <= '0;
      lowData_q <= '0;
      age_q     <= '0;
      rfWe_q    <= 1'b0;
      rfWaddr_q <= '0;
      rfWdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lowPair_q <= lowPair_d;
      lowData_q <= lowData_d;
      age_q     <= age_d;
      rfWe_q    <= grant && (grantAddr != 5'd0);
      if (grant) begin
        rfWaddr_q <= grantAddr;
        rfWdata_q <= grantData;
      end
    end
  end

  assign bus.pipe_stall = stall;
  assign bus.mdu_ready  = !fifoFull;
  assign bus.rf_we      = rfWe_q;
  assign bus.rf_waddr   = rfWaddr_q;
  assign bus.rf_wdata   = rfWdata_q;
  assign bus.busy       = (state_q != IDLE) || !fifoEmpty;

endmodule

// File: doc/wb_write_sched.md
WB_WRITE_SCHED -- requirements
Module: wb_write_sched

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max cycles a queued MDU result waits before forced grant.
REQ-002 Parameter: FIFO_DEPTH, default 2, MDU result queue entries.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 pipe_valid  in  1  writeback-stage register write request.
REQ-006 pipe_rd  in  5  destination register.
REQ-007 pipe_data  in  64  result; single writes use [31:0].
REQ-008 pipe_double  in  1  doubleword write to even/odd pair.
REQ-009 pipe_stall  out  1  upstream pipeline holds; pipe_valid ignored while high.
REQ-010 mdu_valid  in  1  multi-cycle unit result offered.
REQ-011 mdu_ready  out  1  queue not full; transfer when mdu_valid && mdu_ready.
REQ-012 mdu_rd  in  5; mdu_data  in  32  MDU destination and result.
REQ-013 rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  registered single register-file write port.
REQ-014 busy  out  1  FSM not IDLE or queue non-empty.

Function
REQ-015 Write port SHALL be registered: a grant in cycle N SHALL appear on rf_* in cycle N+1.
REQ-016 FSM states SHALL be IDLE and LOW_PEND.
REQ-017 IDLE, pipe_valid, !pipe_double, not forced: SHALL grant pipe; rf_waddr=pipe_rd, rf_wdata=pipe_data[31:0].
REQ-018 IDLE, pipe_valid, pipe_double, not forced: SHALL write pipe_data[63:32] to {pipe_rd[4:1],0}, latch pipe_data[31:0], go to LOW_PEND.
REQ-019 LOW_PEND: SHALL write latched low word to {pipe_rd[4:1],1}, return to IDLE; pipe_stall=1 combinationally throughout LOW_PEND.
REQ-020 Pipe SHALL have priority over the queue unless forced (REQ-022).
REQ-021 Queue head SHALL be granted in IDLE when pipe_valid=0 or forced; head popped on grant.
REQ-022 Age counter SHALL count cycles head waits ungranted, saturating at STARVE_LIMIT; at STARVE_LIMIT grant is forced: pipe_stall=1 for that cycle, head granted, counter cleared.
REQ-023 Age counter SHALL clear on every pop and while queue empty.
REQ-024 mdu_ready SHALL be 0 when queue full; push and pop in the same cycle on full queue SHALL NOT assert ready (ready from registered count only).
REQ-025 Simultaneous push and pop SHALL keep count unchanged and preserve FIFO order.
REQ-026 Any grant with destination r0 SHALL occupy the port slot but drive rf_we=0.
REQ-027 Queue SHALL never be granted in LOW_PEND.
REQ-028 pipe_stall SHALL be 1 only in LOW_PEND or forced-grant cycle.

Reset
REQ-029 On reset: state IDLE, queue empty, age 0, rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, mdu_ready=1, busy=0.
REQ-030 Reset mid-LOW_PEND or with queued entries SHALL discard them; no write emitted after reset.

Structure
REQ-031 Package sparc_wb_pkg SHALL hold wb_state_t enum (IDLE, LOW_PEND), defaults of STARVE_LIMIT and FIFO_DEPTH, and mdu_entry_t struct {rd[4:0], data[31:0]}.
REQ-032 Queue SHALL be sub-module wb_mdu_fifo (push/pop/full/empty/head, sync reset).

Verification
REQ-033 Single: pipe_valid, rd=5, data=0x0000_0000_DEAD_BEEF -> next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF.
REQ-034 Double: rd=9, data=0x1111_2222_3333_4444 -> cycles N+1: waddr=8/0x11112222; N+2: waddr=9/0x33334444; pipe_stall=1 in cycle N+1 only.
REQ-035 Priority: mdu push rd=3 while pipe_valid held 4 cycles -> 5th cycle pipe_stall=1, rf writes r3 next cycle; pipe write resumes after.
REQ-036 Full: 3 MDU pushes with pipe_valid continuous -> mdu_ready=0 after 2nd push; 3rd held until pop.
REQ-037 r0: pipe_valid rd=0 -> rf_we stays 0, no stall.
REQ-038 Reset asserted in LOW_PEND with 2 queued -> next cycle rf_we=0, busy=0, mdu_ready=1.
